ext_int_source: RTL and testbench
=================================

# ext_int_source

External interrupt source that drives the CPU's `interrupt` input and acts as the responder for the interrupt-acknowledge write on `m_int_addr`/`m_int_byteen`. It sits outside `mips`, beside instruction and data memory in the system/bench top. It raises interrupt requests from a manual trigger or a programmable periodic timer, queues them, and holds `interrupt` high until the interrupt handler's acknowledge store is seen. It then applies a hold-off gap before re-asserting for the next queued request.

## Interface
- `ACK_ADDR`, 32'h0000_7F20, word address whose write acknowledges the request.
- `PERIOD`, 200, cycles between periodic events; must be ≥ 2.
- `HOLDOFF`, 2, idle cycles forced after each acknowledge; 0 means no gap.
- `PEND_W`, 3, pending-counter width; saturates at 2^PEND_W−1.

Ports:
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `enable`  in  1  periodic generation enable.
- `trig`  in  1  one-shot request, one event per cycle high.
- `m_int_addr`  in  32  interrupt-acknowledge write address from the CPU bridge.
- `m_int_byteen`  in  4  byte enables for that write; acknowledge requires any bit set.
- `interrupt`  out  1  registered request to the CPU.
- `pend_cnt`  out  PEND_W  queued, unacknowledged requests, including the one being asserted.
- `overflow`  out  1  sticky; an event was lost at saturation.
- `spurious`  out  1  sticky; an acknowledge arrived outside ASSERT.

## Operation
- Reset values:
  - state IDLE
  - `interrupt` 0
  - `pend_cnt` 0
  - `overflow` 0
  - `spurious` 0
  - period counter 0
  - hold-off counter 0
- Period counter runs only while `enable`=1. It counts 0..PERIOD−1, produces a tick at PERIOD−1, then wraps to 0. When `enable`=0 it freezes and does not clear.
- Events per cycle are `trig` plus tick, so 0, 1 or 2.
- Definition: `ack` = (`m_int_addr`==ACK_ADDR) && |`m_int_byteen`, and only when state is ASSERT.
- Pending update: `pend_cnt` ← `pend_cnt` + events − ack.
  - The result saturates at max; any event lost to saturation sets `overflow`.
  - Simultaneous event and ack are netted. At max with one event and an ack, the count stays at max with no overflow.
- States:
  - IDLE: `interrupt`=0. If `pend_cnt`>0, go to ASSERT.
  - ASSERT: `interrupt`=1. On ack, decrement, then go to HOLDOFF if HOLDOFF>0, else IDLE.
  - HOLDOFF: `interrupt`=0. Count HOLDOFF cycles, then go to IDLE. Events still queue during this state.
- An acknowledge-address write in IDLE or HOLDOFF sets `spurious` and leaves `pend_cnt` unaffected apart from event increments.
- `interrupt` is a flop equal to (next state == ASSERT). It never glitches and never depends combinationally on bus inputs.

## Timing
- `trig` sampled at edge k with IDLE and `pend_cnt`=0:
  - `pend_cnt`=1 after edge k.
  - `interrupt`=1 after edge k+1.
  - Latency is 2 cycles.
- Ack sampled at edge j: `interrupt`=0 and `pend_cnt` decremented after edge j.
- With `pend_cnt` still >0 after an ack, re-assert comes after edge j+HOLDOFF+1. The low gap is therefore HOLDOFF+1 cycles, or 1 cycle when HOLDOFF=0.
- Periodic tick: the first tick occurs PERIOD cycles after `enable` rises from reset state.
- `reset` asserted mid-ASSERT: `interrupt`=0 after that edge and all state cleared. Events and acks in the reset cycle are ignored.
- No combinational path from any input to any output.

## Structure
- Package `ext_int_pkg` contains:
  - state enum (IDLE, ASSERT, HOLDOFF)
  - `INT_ACK_ADDR_DEFAULT` = 32'h0000_7F20
  - width localparam helpers for the period and hold-off counters
- Sub-module `int_period_timer` (`clk`, `reset`, `enable`, `tick`) holds the period counter. The top holds the FSM, the pending counter and the sticky flags.

## Test plan
- Reset then `trig` for 1 cycle at edge 10 → `pend_cnt`=1 after edge 10, `interrupt`=1 after edge 11. Hold no ack for 50 cycles → `interrupt` stays 1.
- In ASSERT, drive `m_int_addr`=0x7F20, `m_int_byteen`=4'b0001 for 1 cycle → `interrupt` drops the next cycle and `pend_cnt`=0. Repeat with `m_int_byteen`=0 → no ack, `interrupt` stays 1.
- Queue 3 trigs, then ack each promptly with HOLDOFF=2 → three separate pulses, each followed by a 3-cycle low gap, and `pend_cnt` goes 3→2→1→0.
- `trig` held for 9 cycles with no acks, PEND_W=3 → `pend_cnt` saturates at 7 and `overflow`=1. On the cycle `pend_cnt`=7, drive `trig` and an ack together → `pend_cnt` stays 7.
- `enable`=1 with PERIOD=5 → ticks at cycles 5, 10, 15. Drop `enable` for 3 cycles → the next tick is delayed by 3 cycles. A `trig` coinciding with a tick → `pend_cnt` increases by 2.
- Ack-address write while IDLE → `spurious`=1 and `pend_cnt` unchanged. Assert `reset` during ASSERT → all outputs 0 after that edge.

Source files
------------

// File: rtl/ext_int_pkg.sv
// Shared types and helpers for the external interrupt source.
package ext_int_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ASSERT,
    S_HOLDOFF
  } int_state_t;

  localparam logic [31:0] INT_ACK_ADDR_DEFAULT = 32'h0000_7F20;

  // Width of a counter that runs 0..n-1; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/int_period_timer.sv
// Free-running period counter; emits a one-cycle tick at PERIOD-1, freezes while disabled.
module int_period_timer
  import ext_int_pkg::*;
#(
  parameter int PERIOD = 200
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic tick
);

  localparam int W = cnt_w(PERIOD);
  localparam logic [W-1:0] LAST = W'(PERIOD - 1);

  logic [W-1:0] cnt;

  assign tick = enable && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (reset)       cnt <= '0;
    else if (enable) cnt <= tick ? '0 : cnt + 1'b1;
  end

endmodule

// File: rtl/ext_int_source.sv
// Interrupt request source: queues trig/timer events and holds interrupt until the
// handler's acknowledge store, then enforces a hold-off gap before the next request.
module ext_int_source
  import ext_int_pkg::*;
#(
  parameter logic [31:0] ACK_ADDR = INT_ACK_ADDR_DEFAULT,
  parameter int          PERIOD   = 200,
  parameter int          HOLDOFF  = 2,
  parameter int          PEND_W   = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              trig,
  input  logic [31:0]       m_int_addr,
  input  logic [3:0]        m_int_byteen,
  output logic              interrupt,
  output logic [PEND_W-1:0] pend_cnt,
  output logic              overflow,
  output logic              spurious
);

  localparam int HO_W  = cnt_w(HOLDOFF);
  localparam int SUM_W = PEND_W + 2;
  localparam logic [HO_W-1:0]  HO_LAST = HO_W'((HOLDOFF > 0) ? HOLDOFF - 1 : 0);
  localparam logic [SUM_W-1:0] PMAX    = SUM_W'((1 << PEND_W) - 1);

  int_state_t       state, state_nx;
  logic [HO_W-1:0]  ho_cnt;
  logic             tick, addr_hit, ack;
  logic [1:0]       events;
  logic [SUM_W-1:0] sum;
  logic [PEND_W-1:0] pend_nx;
  logic             lost;

  int_period_timer #(.PERIOD(PERIOD)) u_timer (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .tick   (tick)
  );

  assign addr_hit = (m_int_addr == ACK_ADDR) && (|m_int_byteen);
  assign ack      = addr_hit && (state == S_ASSERT);
  assign events   = {1'b0, trig} + {1'b0, tick};

  // ack is only possible in ASSERT, where pend_cnt is at least 1, so no underflow.
  always_comb begin
    sum     = SUM_W'(pend_cnt) + SUM_W'(events) - SUM_W'(ack);
    lost    = sum > PMAX;
    pend_nx = lost ? PMAX[PEND_W-1:0] : sum[PEND_W-1:0];
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:    if (pend_cnt != '0) state_nx = S_ASSERT;
      S_ASSERT:  if (ack) state_nx = (HOLDOFF > 0) ? S_HOLDOFF : S_IDLE;
      S_HOLDOFF: if (ho_cnt == HO_LAST) state_nx = S_IDLE;
      default:   state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      ho_cnt    <= '0;
      interrupt <= 1'b0;
      pend_cnt  <= '0;
      overflow  <= 1'b0;
      spurious  <= 1'b0;
    end else begin
      state     <= state_nx;
      ho_cnt    <= (state == S_HOLDOFF) ? ho_cnt + 1'b1 : '0;
      interrupt <= (state_nx == S_ASSERT);
      pend_cnt  <= pend_nx;
      if (lost)                             overflow <= 1'b1;
      if (addr_hit && (state != S_ASSERT))  spurious <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ext_int_source.sv
// Directed bench for ext_int_source with PERIOD=5, HOLDOFF=2, PEND_W=3.
module tb_ext_int_source;

  logic        clk = 1'b0;
  logic        reset, enable, trig;
  logic [31:0] m_int_addr;
  logic [3:0]  m_int_byteen;
  logic        interrupt, overflow, spurious;
  logic [2:0]  pend_cnt;

  int vectors    = 0;
  int miscompares = 0;

  ext_int_source #(
    .ACK_ADDR (32'h0000_7F20),
    .PERIOD   (5),
    .HOLDOFF  (2),
    .PEND_W   (3)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .trig         (trig),
    .m_int_addr   (m_int_addr),
    .m_int_byteen (m_int_byteen),
    .interrupt    (interrupt),
    .pend_cnt     (pend_cnt),
    .overflow     (overflow),
    .spurious     (spurious)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all0(input string tag);
    check({tag, ".int"},  32'(interrupt), 32'd0);
    check({tag, ".pend"}, 32'(pend_cnt),  32'd0);
    check({tag, ".ovf"},  32'(overflow),  32'd0);
    check({tag, ".spur"}, 32'(spurious),  32'd0);
  endtask

  task automatic ack_on();
    m_int_addr   = 32'h0000_7F20;
    m_int_byteen = 4'b0001;
  endtask

  task automatic ack_off();
    m_int_addr   = 32'h0;
    m_int_byteen = 4'b0000;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; trig = 1'b0;
    ack_off();
    step(); step();
    reset = 1'b0;
    check_all0("reset");

    // trig sampled at edge 10: pend after 10, interrupt after 11
    repeat (9) step();
    trig = 1'b1;
    step();
    trig = 1'b0;
    check("trig.pend", 32'(pend_cnt), 32'd1);
    check("trig.int_lat1", 32'(interrupt), 32'd0);
    step();
    check("trig.int_lat2", 32'(interrupt), 32'd1);
    for (int i = 0; i < 50; i++) begin
      step();
      check("noack.hold", 32'(interrupt), 32'd1);
    end

    // byte enables all clear: not an acknowledge
    m_int_addr = 32'h0000_7F20; m_int_byteen = 4'b0000;
    step();
    ack_off();
    check("be0.int",  32'(interrupt), 32'd1);
    check("be0.pend", 32'(pend_cnt),  32'd1);
    check("be0.spur", 32'(spurious),  32'd0);
    ack_on();
    step();
    ack_off();
    check("ack.int",  32'(interrupt), 32'd0);
    check("ack.pend", 32'(pend_cnt),  32'd0);
    repeat (4) step();
    check("ack.idle", 32'(interrupt), 32'd0);

    // three queued requests, each acked promptly: 3-cycle low gaps
    trig = 1'b1;
    repeat (3) step();
    trig = 1'b0;
    check("q3.pend", 32'(pend_cnt), 32'd3);
    check("q3.int",  32'(interrupt), 32'd1);
    for (int n = 3; n >= 1; n--) begin
      check("q.pre_int",  32'(interrupt), 32'd1);
      check("q.pre_pend", 32'(pend_cnt), 32'(n));
      ack_on();
      step();
      ack_off();
      check("q.ack_int",  32'(interrupt), 32'd0);
      check("q.ack_pend", 32'(pend_cnt), 32'(n - 1));
      step(); check("q.gap1", 32'(interrupt), 32'd0);
      step(); check("q.gap2", 32'(interrupt), 32'd0);
      step(); check("q.reassert", 32'(interrupt), (n > 1) ? 32'd1 : 32'd0);
    end
    check("q.spur", 32'(spurious), 32'd0);

    // saturation: 7 trigs reach max, 2 more are lost
    trig = 1'b1;
    repeat (7) step();
    check("sat7.pend", 32'(pend_cnt), 32'd7);
    check("sat7.ovf",  32'(overflow), 32'd0);
    repeat (2) step();
    check("sat9.pend", 32'(pend_cnt), 32'd7);
    check("sat9.ovf",  32'(overflow), 32'd1);
    ack_on();
    step();
    ack_off();
    trig = 1'b0;
    check("satack.pend", 32'(pend_cnt), 32'd7);
    check("satack.int",  32'(interrupt), 32'd0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_all0("reset2");

    // periodic ticks at 5,10,15; enable low 16..18 shifts next to 23; trig+tick at 28
    for (int c = 1; c <= 28; c++) begin
      enable = !(c >= 16 && c <= 18);
      trig   = (c == 28);
      step();
      case (c)
        4:  check("tick.c4",  32'(pend_cnt), 32'd0);
        5:  check("tick.c5",  32'(pend_cnt), 32'd1);
        9:  check("tick.c9",  32'(pend_cnt), 32'd1);
        10: check("tick.c10", 32'(pend_cnt), 32'd2);
        14: check("tick.c14", 32'(pend_cnt), 32'd2);
        15: check("tick.c15", 32'(pend_cnt), 32'd3);
        22: check("tick.c22", 32'(pend_cnt), 32'd3);
        23: check("tick.c23", 32'(pend_cnt), 32'd4);
        27: check("tick.c27", 32'(pend_cnt), 32'd4);
        28: check("tick.c28", 32'(pend_cnt), 32'd6);
        default: ;
      endcase
    end
    enable = 1'b0; trig = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_all0("reset3");

    // acknowledge-address write while idle is spurious
    ack_on();
    step();
    ack_off();
    check("spur.flag", 32'(spurious), 32'd1);
    check("spur.pend", 32'(pend_cnt), 32'd0);
    check("spur.int",  32'(interrupt), 32'd0);

    // reset in the middle of ASSERT, with an event and ack in the same cycle
    trig = 1'b1;
    step();
    trig = 1'b0;
    step();
    check("pre_rst.int", 32'(interrupt), 32'd1);
    reset = 1'b1; trig = 1'b1;
    ack_on();
    step();
    reset = 1'b0; trig = 1'b0;
    ack_off();
    check_all0("rst_assert");
    step();
    check_all0("rst_after");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
